// File: rtl/edsac_timing_pkg.sv
// Shared timing constants and state types for the EDSAC serial arithmetic registers.
//   WORD_LEN  : digit periods per long word (35 data digits plus 1 gap digit)
//   SHORT_LEN : data digits in a short number
//   DIG_C18   : digit that ends the first minor cycle
//   DIG_D35   : gap digit at the end of a long word
//   mcand_state_t : multiplicand tank load state
package edsac_timing_pkg;

    localparam int unsigned WORD_LEN  = 36;
    localparam int unsigned SHORT_LEN = 17;
    localparam int unsigned DIG_C18   = 17;
    localparam int unsigned DIG_D35   = 35;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StArmed   = 2'd1,
        StLoading = 2'd2,
        StHeld    = 2'd3
    } mcand_state_t;

endpackage

// File: rtl/digit_counter.sv
// Digit counter for a serial word: counts 0..NUM_DIGITS-1, resynchronised by word_start,
// with a sticky sync error flag and registered d35/c18 digit strobes.
// Ports:
//   clk, rst_n  : digit clock, asynchronous active-low reset
//   clear       : synchronous clear of sync_err (the count keeps running)
//   word_start  : pulse during the gap digit; forces the next digit to 0
//   dig         : current digit number
//   dig_next    : digit number for the following cycle
//   d35, c18    : high during the last digit / the C18 digit
//   sync_err    : sticky, word_start seen while dig was not the last digit
module digit_counter
    import edsac_timing_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = WORD_LEN,
    parameter int unsigned C18_DIGIT  = DIG_C18,
    parameter int unsigned DIG_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             word_start,
    output logic [DIG_W-1:0] dig,
    output logic [DIG_W-1:0] dig_next,
    output logic             d35,
    output logic             c18,
    output logic             sync_err
);

    localparam logic [DIG_W-1:0] LastDig = DIG_W'(NUM_DIGITS - 1);
    localparam logic [DIG_W-1:0] C18Dig  = DIG_W'(C18_DIGIT);

    logic [DIG_W-1:0] dig_q, dig_d;
    logic             d35_q, d35_d;
    logic             c18_q, c18_d;
    logic             sync_err_q, sync_err_d;

    always_comb begin
        dig_d = dig_q + 1'b1;
        if (word_start || (dig_q == LastDig)) begin
            dig_d = '0;
        end

        sync_err_d = sync_err_q | (word_start && (dig_q != LastDig));
        if (clear) begin
            sync_err_d = 1'b0;
        end

        // Strobes decode the next count so they line up with dig once registered.
        d35_d = (dig_d == LastDig);
        c18_d = (dig_d == C18Dig);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q      <= '0;
            d35_q      <= 1'b0;
            c18_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            dig_q      <= dig_d;
            d35_q      <= d35_d;
            c18_q      <= c18_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign dig      = dig_q;
    assign dig_next = dig_d;
    assign d35      = d35_q;
    assign c18      = c18_q;
    assign sync_err = sync_err_q;

endmodule

// File: rtl/multiplicand_tank.sv
// Serial multiplicand store. Loads a 17- or 35-bit number LSB first from mib during one
// word period, then replays it every word period on dx, aligned to the digit counter.
// Ports:
//   clk, rst_n  : digit clock, asynchronous active-low reset
//   word_start  : timing-chain pulse; the cycle after it is digit 0
//   mib         : serial memory input bus, LSB first
//   load_req    : load request (ignored while armed or loading)
//   long_word   : 1 = 35-bit number, 0 = 17-bit number; captured with load_req
//   clear       : synchronous clear of tank, state machine and sync_err
//   dx          : serial multiplicand, bit k during digit k while held
//   d35, c18    : digit strobes for the multiplier
//   loaded      : tank holds a valid number
//   busy        : load armed or in progress
//   sync_err    : sticky word_start misalignment flag
module multiplicand_tank
    import edsac_timing_pkg::*;
#(
    parameter int unsigned WORD_LEN  = 36,
    parameter int unsigned SHORT_LEN = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic word_start,
    input  logic mib,
    input  logic load_req,
    input  logic long_word,
    input  logic clear,
    output logic dx,
    output logic d35,
    output logic c18,
    output logic loaded,
    output logic busy,
    output logic sync_err
);

    localparam int unsigned      DigW    = $clog2(WORD_LEN);
    localparam logic [DigW-1:0] LastDig = DigW'(WORD_LEN - 1);
    localparam logic [DigW-1:0] ShortLn = DigW'(SHORT_LEN);

    logic [DigW-1:0] dig;
    logic [DigW-1:0] dig_next;

    mcand_state_t state_q, state_d;
    logic         lw_q, lw_d;
    logic [WORD_LEN-1:0] tank_q, tank_d;
    logic         load_bit;
    logic         tank_sel;
    logic         dx_q, dx_d;
    logic         busy_q, busy_d;
    logic         loaded_q, loaded_d;

    digit_counter #(
        .NUM_DIGITS (WORD_LEN),
        .C18_DIGIT  (DIG_C18),
        .DIG_W      (DigW)
    ) u_digit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .word_start (word_start),
        .dig        (dig),
        .dig_next   (dig_next),
        .d35        (d35),
        .c18        (c18),
        .sync_err   (sync_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            lw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lw_q    <= lw_d;
        end
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        lw_d    = lw_q;
        if (clear) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty, StHeld: begin
                    if (load_req) begin
                        state_d = StArmed;
                        lw_d    = long_word;
                    end
                end
                StArmed: begin
                    if (word_start) begin
                        state_d = StLoading;
                    end
                end
                StLoading: begin
                    if (dig == LastDig) begin
                        state_d = StHeld;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Load mux: gap digit forced to 0; short numbers sign-extend from the stored bit 16,
    // which was written at the end of digit SHORT_LEN-1.
    always_comb begin
        if (dig == LastDig) begin
            load_bit = 1'b0;
        end else if (lw_q || (dig < ShortLn)) begin
            load_bit = mib;
        end else begin
            load_bit = tank_q[SHORT_LEN-1];
        end
    end

    // The tank is addressed by digit number instead of being physically shifted. This is
    // equivalent to a tank rotating in step with dig, and a word_start resync realigns the
    // replay to the new digit 0 without needing a barrel rotate.
    always_comb begin
        tank_d = tank_q;
        if (clear) begin
            tank_d = '0;
        end else if (state_q == StLoading) begin
            for (int unsigned k = 0; k < WORD_LEN; k++) begin
                if (dig == DigW'(k)) begin
                    tank_d[k] = load_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tank_q <= '0;
        end else begin
            tank_q <= tank_d;
        end
    end

    // Output logic; computed from the next state so every output comes straight off a flop.
    always_comb begin
        tank_sel = 1'b0;
        for (int unsigned k = 0; k < WORD_LEN; k++) begin
            if (dig_next == DigW'(k)) begin
                tank_sel = tank_q[k];
            end
        end
        dx_d     = (state_d == StHeld) ? tank_sel : 1'b0;
        busy_d   = (state_d == StArmed) || (state_d == StLoading);
        loaded_d = (state_d == StHeld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q     <= 1'b0;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            dx_q     <= dx_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
        end
    end

    assign dx     = dx_q;
    assign busy   = busy_q;
    assign loaded = loaded_q;

endmodule

// File: tb/tb_multiplicand_tank.sv
// Self-checking bench for multiplicand_tank: table-driven loads plus hand-written
// sequences for resync, missing word_start, clear and reset corner cases.
module tb_multiplicand_tank;

    logic clk;
    logic rst_n;
    logic word_start;
    logic mib;
    logic load_req;
    logic long_word;
    logic clear;
    logic dx;
    logic d35;
    logic c18;
    logic loaded;
    logic busy;
    logic sync_err;

    int tests;
    int errors;
    int ph;       // expected digit number of the current cycle
    bit auto_ws;  // generate word_start during digit 35

    typedef struct {
        string       name;
        logic [35:0] mib_bits;
        logic        lw;
        logic [35:0] exp;
    } vec_t;

    vec_t vecs[4];

    multiplicand_tank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_start (word_start),
        .mib        (mib),
        .load_req   (load_req),
        .long_word  (long_word),
        .clear      (clear),
        .dx         (dx),
        .d35        (d35),
        .c18        (c18),
        .loaded     (loaded),
        .busy       (busy),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at dig %0d: got %b, expected %b", name, ph, act, exp);
        end
    endtask

    // Advance one digit and sample 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (word_start || ph == 35) ph = 0;
        else ph = ph + 1;
        word_start = auto_ws && (ph == 35);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_dx"}, dx, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_loaded"}, loaded, 1'b0);
    endtask

    // One full word of held replay starting at digit 0.
    task automatic check_word(input string name, input logic [35:0] exp, input logic se);
        for (int k = 0; k < 36; k++) begin
            chk({name, "_dx"}, dx, exp[ph]);
            chk({name, "_d35"}, d35, ph == 35);
            chk({name, "_c18"}, c18, ph == 17);
            chk({name, "_loaded"}, loaded, 1'b1);
            chk({name, "_busy"}, busy, 1'b0);
            chk({name, "_sync_err"}, sync_err, se);
            cycle();
        end
    endtask

    // Arm and wait for the word_start cycle; returns in LOADING digit 0.
    task automatic arm(input string name, input logic lw);
        int n;
        load_req  = 1'b1;
        long_word = lw;
        cycle();
        load_req  = 1'b0;
        long_word = ~lw;
        chk({name, "_arm_busy"}, busy, 1'b1);
        chk({name, "_arm_dx"}, dx, 1'b0);
        chk({name, "_arm_loaded"}, loaded, 1'b0);
        n = 0;
        while (ph != 35 && n < 40) begin
            cycle();
            n++;
        end
        chk({name, "_arm_timeout"}, ph == 35, 1'b1);
        cycle();
    endtask

    task automatic do_load(input string name, input logic [35:0] bits, input logic lw);
        arm(name, lw);
        for (int k = 0; k < 36; k++) begin
            mib = bits[k];
            if (k == 0 || k == 20) begin
                chk({name, "_ld_busy"}, busy, 1'b1);
                chk({name, "_ld_dx"}, dx, 1'b0);
            end
            cycle();
        end
        mib = 1'b0;
    endtask

    initial begin
        tests      = 0;
        errors     = 0;
        ph         = 0;
        auto_ws    = 1'b1;
        rst_n      = 1'b0;
        word_start = 1'b0;
        mib        = 1'b0;
        load_req   = 1'b0;
        long_word  = 1'b0;
        clear      = 1'b0;

        vecs[0] = '{"long_5",     36'hC_0000_0005, 1'b1, 36'h4_0000_0005};
        vecs[1] = '{"short_neg",  36'h0_0001_0003, 1'b0, 36'h7_FFFF_0003};
        vecs[2] = '{"short_pos",  36'hF_FFFE_5A5A, 1'b0, 36'h0_0000_5A5A};
        vecs[3] = '{"long_ones",  36'hF_FFFF_FFFF, 1'b1, 36'h7_FFFF_FFFF};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
        chk("rst_d35", d35, 1'b0);
        chk("rst_c18", c18, 1'b0);
        chk("rst_sync_err", sync_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph    = 0;

        // Two idle words: strobes only.
        for (int k = 0; k < 72; k++) begin
            check_idle("idle");
            chk("idle_d35", d35, ph == 35);
            chk("idle_c18", c18, ph == 17);
            chk("idle_sync_err", sync_err, 1'b0);
            cycle();
        end

        // Table-driven loads, each replayed for two words.
        for (int i = 0; i < 4; i++) begin
            do_load(vecs[i].name, vecs[i].mib_bits, vecs[i].lw);
            check_word(vecs[i].name, vecs[i].exp, 1'b0);
            check_word(vecs[i].name, vecs[i].exp, 1'b0);
        end

        // Resync: word_start at digit 20 restarts the count and the replay.
        do_load("resync", vecs[0].mib_bits, 1'b1);
        while (ph != 20) cycle();
        chk("resync_pre_err", sync_err, 1'b0);
        word_start = 1'b1;
        cycle();
        chk("resync_dig0", ph == 0, 1'b1);
        chk("resync_err", sync_err, 1'b1);
        check_word("resync", vecs[0].exp, 1'b1);

        // Missing word_start while held: counter free-runs.
        auto_ws    = 1'b0;
        word_start = 1'b0;
        check_word("nows", vecs[0].exp, 1'b1);
        check_word("nows", vecs[0].exp, 1'b1);
        auto_ws = 1'b1;
        word_start = (ph == 35);

        // Clear from HELD.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check_idle("clr_held");
        chk("clr_held_sync_err", sync_err, 1'b0);

        // Clear during LOADING at digit 10 with a simultaneous load_req.
        arm("clr_ld", 1'b1);
        mib = 1'b1;
        while (ph != 10) cycle();
        clear    = 1'b1;
        load_req = 1'b1;
        cycle();
        clear    = 1'b0;
        load_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            check_idle("clr_ld");
            cycle();
        end

        // Reset asserted mid-load at digit 12.
        arm("rst_ld", 1'b1);
        mib = 1'b1;
        while (ph != 12) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("rst_ld");
        chk("rst_ld_d35", d35, 1'b0);
        chk("rst_ld_c18", c18, 1'b0);
        chk("rst_ld_sync_err", sync_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ph         = 0;
        word_start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            check_idle("post_rst");
            chk("post_rst_sync_err", sync_err, 1'b0);
            cycle();
        end
        mib = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
